flappy_game_ctrl: RTL and testbench

- Top-level game sequencer for the Flappy VGA design.
- Drives the Start/Stop/Ack handshake of the pipe X-coordinate store and generates the frame-rate move tick that paces pipe scrolling and bird physics.
- Turns the player button into single-cycle flap pulses, ends the game on collision, and latches the high score.

---
 rtl/flappy_game_ctrl.sv | 144 ++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: IDLE/RUN/OVER/CLEAR FSM, pipe-store Start/Stop/Ack handshake, move-tick prescaler,
// synchronised button edge -> flap pulse, high-score latch. All outputs registered; no backpressure.
module flappy_game_ctrl #(
  parameter int TICK_DIV  = 250000,
  parameter int OVER_HOLD = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       collide,
  input  logic [3:0] score_in,
  input  logic       store_initial,
  input  logic       store_stop,
  output logic       start,
  output logic       stop,
  output logic       ack,
  output logic       move_tick,
  output logic       flap,
  output logic [3:0] high_score,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    OVER  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  localparam logic [17:0] TICK_MAX = 18'(TICK_DIV - 1);
  localparam logic [7:0]  HOLD_MAX = 8'(OVER_HOLD);

  state_t      state_q, state_d;
  logic        meta_q, meta_d, sync_q, sync_d, sync_qq, sync_qq_d;
  logic [17:0] cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        over_new_q, over_new_d;
  logic        start_q, start_d, stop_q, stop_d, ack_q, ack_d;
  logic        tick_q, tick_d, flap_q, flap_d;
  logic [3:0]  hs_q, hs_d;
  logic        press, tick_int, in_cnt;

  always_comb begin
    meta_d     = btn;
    sync_d     = meta_q;
    sync_qq_d  = sync_q;
    press      = sync_q & ~sync_qq;
    tick_int   = (state_q == OVER) && (cnt_q == TICK_MAX);
    state_d    = state_q;
    hold_d     = hold_q;
    hs_d       = hs_q;
    over_new_d = 1'b0;
    stop_d     = 1'b0;
    ack_d      = 1'b0;
    flap_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (press && store_initial) begin
          state_d = RUN;
          flap_d  = 1'b1;
        end
      end
      RUN: begin
        // Collision outranks a simultaneous press.
        if (collide) begin
          state_d    = OVER;
          stop_d     = 1'b1;
          over_new_d = 1'b1;
          hs_d       = (score_in > hs_q) ? score_in : hs_q;
        end else begin
          flap_d = press;
        end
      end
      OVER: begin
        if (tick_int && (hold_q < HOLD_MAX)) hold_d = hold_q + 8'd1;
        if (press && (hold_q == HOLD_MAX)) begin
          state_d = CLEAR;
          ack_d   = 1'b1;
        end else begin
          // Stop is guaranteed for the collide cycle and the one after it.
          stop_d = over_new_q | (stop_q & ~store_stop);
        end
      end
      CLEAR: begin
        if (store_initial) begin
          state_d = IDLE;
          hold_d  = 8'd0;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Prescaler runs through RUN and OVER, restarting at 0 on RUN entry.
    in_cnt  = ((state_d == RUN) || (state_d == OVER)) &&
              ((state_q == RUN) || (state_q == OVER));
    cnt_d   = (!in_cnt || (cnt_q == TICK_MAX)) ? 18'd0 : cnt_q + 18'd1;
    start_d = (state_d == IDLE) && store_initial;
    tick_d  = (state_d == RUN) && (cnt_d == TICK_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_qq    <= 1'b0;
      cnt_q      <= 18'd0;
      hold_q     <= 8'd0;
      over_new_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      ack_q      <= 1'b0;
      tick_q     <= 1'b0;
      flap_q     <= 1'b0;
      hs_q       <= 4'd0;
    end else begin
      state_q    <= state_d;
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      sync_qq    <= sync_qq_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      over_new_q <= over_new_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      ack_q      <= ack_d;
      tick_q     <= tick_d;
      flap_q     <= flap_d;
      hs_q       <= hs_d;
    end
  end

  assign start      = start_q;
  assign stop       = stop_q;
  assign ack        = ack_q;
  assign move_tick  = tick_q;
  assign flap       = flap_q;
  assign high_score = hs_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Scoreboard bench for flappy_game_ctrl with TICK_DIV=4, OVER_HOLD=2.
module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, btn, collide, store_initial, store_stop;
  logic [3:0] score_in;
  logic       start, stop, ack, move_tick, flap;
  logic [3:0] high_score;
  logic [1:0] game_state;

  flappy_game_ctrl #(.TICK_DIV(4), .OVER_HOLD(2)) dut (
    .clk(clk), .reset(reset), .btn(btn), .collide(collide), .score_in(score_in),
    .store_initial(store_initial), .store_stop(store_stop),
    .start(start), .stop(stop), .ack(ack), .move_tick(move_tick), .flap(flap),
    .high_score(high_score), .game_state(game_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic [3:0] hs;
  } st_exp_t;

  st_exp_t st_q[$];
  int      flap_q[$];
  int      stop_q[$];
  int      ack_q[$];
  int      n_cmp = 0;
  int      n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm);
    int k = 0;
    while (game_state != s && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(nm, game_state, s);
  endtask

  task automatic press_btn(input int hold);
    btn = 1'b1;
    wait_neg(hold);
    btn = 1'b0;
  endtask

  task automatic start_game(input logic [3:0] hs, input int hold);
    st_q.push_back('{2'b01, hs});
    flap_q.push_back(1);
    btn = 1'b1;
    wait_neg(2);
    chk("pre_run_state", game_state, 0);
    wait_neg(1);
    chk("run_after_3", game_state, 1);
    chk("flap_on_entry", flap, 1);
    wait_neg(hold - 3);
    btn = 1'b0;
    store_initial = 1'b0;
  endtask

  task automatic finish_game(input logic [3:0] score, input logic [3:0] hs);
    st_q.push_back('{2'b10, hs});
    stop_q.push_back(2);
    score_in   = score;
    store_stop = 1'b1;
    collide    = 1'b1;
    wait_neg(1);
    collide = 1'b0;
    wait_state(2'b10, "enter_over");
  endtask

  task automatic restart(input logic [3:0] hs, input int ack_wait);
    wait_neg(12);
    st_q.push_back('{2'b11, hs});
    press_btn(3);
    wait_state(2'b11, "enter_clear");
    wait_neg(ack_wait);
    st_q.push_back('{2'b00, hs});
    ack_q.push_back(ack_wait + 1);
    store_initial = 1'b1;
    store_stop    = 1'b0;
    wait_state(2'b00, "back_idle");
    chk("idle_start", start, 1);
    chk("idle_ack", ack, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  int         ncyc = 0;
  int         last_tick = -1;
  int         stop_len = 0;
  int         ack_len = 0;
  logic [1:0] prev_state = 2'b00;

  initial begin
    st_exp_t e;
    int      f;
    forever begin
      @(negedge clk);
      ncyc++;
      if (game_state != prev_state) begin
        chk("state_evt_pending", int'(st_q.size() != 0), 1);
        if (st_q.size() != 0) begin
          e = st_q.pop_front();
          chk("state_val", game_state, e.st);
          chk("state_high_score", high_score, e.hs);
        end
        prev_state = game_state;
      end
      if (flap) begin
        chk("flap_pending", int'(flap_q.size() != 0), 1);
        if (flap_q.size() != 0) begin
          f = flap_q.pop_front();
          chk("flap_state", game_state, f);
        end
      end
      if (move_tick) begin
        chk("tick_in_run", game_state, 1);
        if (last_tick >= 0) chk("tick_gap", ncyc - last_tick, 4);
        last_tick = ncyc;
      end
      if (game_state != 2'b01) last_tick = -1;
      if (start | stop | ack) chk("handshake_excl", int'(start) + int'(stop) + int'(ack), 1);
      if (stop) stop_len++;
      else if (stop_len > 0) begin
        chk("stop_pending", int'(stop_q.size() != 0), 1);
        if (stop_q.size() != 0) chk("stop_len", stop_len, stop_q.pop_front());
        stop_len = 0;
      end
      if (ack) ack_len++;
      else if (ack_len > 0) begin
        chk("ack_pending", int'(ack_q.size() != 0), 1);
        if (ack_q.size() != 0) chk("ack_len", ack_len, ack_q.pop_front());
        ack_len = 0;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, game_state, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_stop"}, stop, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_tick"}, move_tick, 0);
    chk({tag, "_flap"}, flap, 0);
    chk({tag, "_high_score"}, high_score, 0);
  endtask

  initial begin
    int idle_ticks = 0;
    reset = 1'b0; btn = 1'b0; collide = 1'b0; score_in = 4'd0;
    store_initial = 1'b0; store_stop = 1'b0;
    #3;
    chk_all_zero("reset");
    wait_neg(2);
    reset = 1'b1;
    store_initial = 1'b1;
    wait_neg(2);
    chk("idle_start_hi", start, 1);
    chk("idle_state", game_state, 0);
    repeat (8) begin
      @(negedge clk);
      if (move_tick) idle_ticks++;
    end
    chk("idle_no_tick", idle_ticks, 0);

    // Game 1: presses, glitch, single-cycle pulse, score 3, early press in OVER ignored
    start_game(4'd0, 10);
    wait_neg(12);
    repeat (3) begin
      flap_q.push_back(1);
      press_btn(3);
      wait_neg(3);
    end
    @(negedge clk);
    #2 btn = 1'b1;
    #2 btn = 1'b0;
    wait_neg(5);
    flap_q.push_back(1);
    press_btn(1);
    wait_neg(5);
    finish_game(4'd3, 4'd3);
    press_btn(2);
    wait_neg(6);
    chk("over_early_press_ignored", game_state, 2);
    restart(4'd3, 3);
    chk("high_score_3", high_score, 3);

    // Game 2: score 7 raises high score
    start_game(4'd3, 4);
    wait_neg(6);
    finish_game(4'd7, 4'd7);
    chk("high_score_7", high_score, 7);
    restart(4'd7, 1);

    // Game 3: press and collide in the same cycle, lower score keeps 7
    start_game(4'd7, 4);
    wait_neg(5);
    st_q.push_back('{2'b10, 4'd7});
    stop_q.push_back(2);
    score_in   = 4'd5;
    store_stop = 1'b1;
    btn = 1'b1;
    wait_neg(2);
    collide = 1'b1;
    wait_neg(1);
    collide = 1'b0;
    wait_state(2'b10, "collide_wins");
    wait_neg(2);
    btn = 1'b0;
    chk("high_score_keep_7", high_score, 7);
    restart(4'd7, 1);

    // Game 4: asynchronous reset mid-RUN
    start_game(4'd7, 4);
    wait_neg(5);
    #2;
    st_q.push_back('{2'b00, 4'd0});
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    wait_neg(2);
    reset = 1'b1;
    store_initial = 1'b1;
    wait_neg(4);

    chk("st_queue_drained", st_q.size(), 0);
    chk("flap_queue_drained", flap_q.size(), 0);
    chk("stop_queue_drained", stop_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
